wb_dma_slv_rsp: RTL and testbench

Wishbone classic slave (responder) that terminates the DMA engine's master0/master1 read and write cycles.
- Backs an internal word-addressed RAM with byte-enabled writes.
- Programmable wait states, address-range error termination and retry injection.
- Serves as the far end of the DMA engine's read/write/ack handshake for descriptor loads, data reads and writes, in system integration and bench use.

---
 rtl/wb_dma_slv_rsp_pkg.sv | 40 ++++
 rtl/wb_dma_slv_rsp_if.sv | 30 +++
 rtl/wb_dma_slv_rsp_ram.sv | 36 +++
 rtl/wb_dma_slv_rsp.sv | 181 ++++++++++++++++++
 tb/tb_wb_dma_slv_rsp.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_dma_slv_rsp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_dma_slv_pkg
//  Brief    : Shared types and constants for the Wishbone DMA slave responder.
//  Revision : 1.0  initial release
// ============================================================================
package wb_dma_slv_pkg;

    // Width of the wait-state request and of the internal wait counter
    localparam int WS_W = 4;

    // Responder FSM, one-hot encoded
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        WAIT = 3'b010,
        RESP = 3'b100
    } state_e;

    // Kind of termination issued at the end of a transfer
    typedef enum logic [1:0] {
        T_ACK = 2'd0,
        T_ERR = 2'd1,
        T_RTY = 2'd2
    } term_e;

    // Termination priority: address miss beats retry injection beats ack
    function automatic term_e resolve_term(input logic hit, input logic rty);
        term_e t;
        if (!hit) begin
            t = T_ERR;
        end else if (rty) begin
            t = T_RTY;
        end else begin
            t = T_ACK;
        end
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_dma_slv_rsp_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_dma_slv_rsp_if
//  Brief    : Wishbone classic bus bundle between a DMA master and the slave
//             responder. Signal suffixes are from the slave's point of view.
//  Revision : 1.0  initial release
// ============================================================================
interface wb_dma_slv_rsp_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_data_i;
    logic [31:0] wb_data_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_data_i,
        input  wb_data_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_data_i,
        output wb_data_o, wb_ack_o, wb_err_o, wb_rty_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_dma_slv_rsp_ram.sv
`default_nettype none
// ============================================================================
//  Module   : wb_dma_slv_ram
//  Brief    : Single-port synchronous 32-bit RAM with byte write enables and
//             a registered read port (read-before-write on the same address).
//  Revision : 1.0  initial release
// ============================================================================
module wb_dma_slv_ram #(
    parameter int MEM_AW = 10
) (
    input  wire logic              clk,
    input  wire logic [MEM_AW-1:0] adr_i,
    input  wire logic [3:0]        we_i,
    input  wire logic [31:0]       dat_i,
    output logic      [31:0]       dat_o
);

    localparam int DEPTH = 2 ** MEM_AW;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] dat_q;

    // Byte-lane writes and a registered read of the addressed word
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem_q[adr_i][i*8 +: 8] <= dat_i[i*8 +: 8];
            end
        end
        dat_q <= mem_q[adr_i];
    end

    assign dat_o = dat_q;

endmodule
`default_nettype wire

// File: rtl/wb_dma_slv_rsp.sv
`default_nettype none
// ============================================================================
//  Module   : wb_dma_slv_rsp
//  Brief    : Wishbone classic slave terminating DMA master cycles against an
//             internal RAM, with programmable wait states, out-of-window error
//             termination and retry injection.
//  Revision : 1.0  initial release
// ============================================================================
module wb_dma_slv_rsp
    import wb_dma_slv_pkg::*;
#(
    parameter int          MEM_AW   = 10,
    parameter logic [31:0] BASE_ADR = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    wb_dma_slv_rsp_if.slave        wb,
    input  wire logic [WS_W-1:0]   ws_i,
    input  wire logic              rty_inject_i,
    output logic      [CNT_W-1:0]  ack_cnt_o,
    output logic      [CNT_W-1:0]  err_cnt_o
);

    state_e              state_q,   state_d;
    logic [WS_W-1:0]     cnt_q,     cnt_d;
    logic [MEM_AW-1:0]   adr_q,     adr_d;
    logic                we_q,      we_d;
    logic [3:0]          sel_q,     sel_d;
    logic [31:0]         wdat_q,    wdat_d;
    logic                hit_q,     hit_d;
    logic                rtyi_q,    rtyi_d;
    logic                ack_q,     ack_d;
    logic                err_q,     err_d;
    logic                rty_q,     rty_d;
    logic [31:0]         rdat_q,    rdat_d;
    logic [CNT_W-1:0]    ack_cnt_q, ack_cnt_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

    logic [MEM_AW-1:0]   ram_adr;
    logic [3:0]          ram_we;
    logic [31:0]         ram_rdat;
    term_e               term;

    // Byte offset bits never select anything inside a 32-bit word
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^wb.wb_adr_i[1:0];

    wb_dma_slv_ram #(
        .MEM_AW (MEM_AW)
    ) u_ram (
        .clk   (clk),
        .adr_i (ram_adr),
        .we_i  (ram_we),
        .dat_i (wdat_q),
        .dat_o (ram_rdat)
    );

    // Next-state, request capture, termination and RAM port control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        we_d      = we_q;
        sel_d     = sel_q;
        wdat_d    = wdat_q;
        hit_d     = hit_q;
        rtyi_d    = rtyi_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rty_d     = 1'b0;
        rdat_d    = rdat_q;
        ack_cnt_d = ack_cnt_q;
        err_cnt_d = err_cnt_q;
        ram_adr   = adr_q;
        ram_we    = 4'b0000;
        term      = resolve_term(hit_q, rtyi_q);

        unique case (state_q)
            IDLE: begin
                // The RAM reads the incoming address so that with zero wait
                // states the word is already registered by the RESP cycle.
                ram_adr = wb.wb_adr_i[MEM_AW+1:2];
                if (wb.wb_cyc_i && wb.wb_stb_i) begin
                    adr_d  = wb.wb_adr_i[MEM_AW+1:2];
                    we_d   = wb.wb_we_i;
                    sel_d  = wb.wb_sel_i;
                    wdat_d = wb.wb_data_i;
                    rtyi_d = rty_inject_i;
                    hit_d  = (wb.wb_adr_i[31:MEM_AW+2] == BASE_ADR[31:MEM_AW+2]);
                    if (ws_i == '0) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = ws_i;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!wb.wb_cyc_i) begin
                    // Master abandoned the cycle: drop it silently
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == WS_W'(1)) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - WS_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                unique case (term)
                    T_ERR: begin
                        err_d     = 1'b1;
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                    T_RTY: begin
                        rty_d = 1'b1;
                    end
                    default: begin
                        ack_d     = 1'b1;
                        ack_cnt_d = ack_cnt_q + CNT_W'(1);
                        if (we_q) begin
                            ram_we = sel_q;
                        end else begin
                            rdat_d = ram_rdat;
                        end
                    end
                endcase
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any transfer in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            adr_q     <= '0;
            we_q      <= 1'b0;
            sel_q     <= 4'b0000;
            wdat_q    <= '0;
            hit_q     <= 1'b0;
            rtyi_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rty_q     <= 1'b0;
            rdat_q    <= '0;
            ack_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            adr_q     <= adr_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            wdat_q    <= wdat_d;
            hit_q     <= hit_d;
            rtyi_q    <= rtyi_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rty_q     <= rty_d;
            rdat_q    <= rdat_d;
            ack_cnt_q <= ack_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign wb.wb_ack_o  = ack_q;
    assign wb.wb_err_o  = err_q;
    assign wb.wb_rty_o  = rty_q;
    assign wb.wb_data_o = rdat_q;
    assign ack_cnt_o    = ack_cnt_q;
    assign err_cnt_o    = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_dma_slv_rsp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_dma_slv_rsp
//  Brief    : Scoreboard testbench for the Wishbone DMA slave responder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_dma_slv_rsp;

    localparam int          MEM_AW = 10;
    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam int          CNT_W  = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       ws_i = 4'd0;
    logic             rty_inject_i = 1'b0;
    logic [CNT_W-1:0] ack_cnt_o;
    logic [CNT_W-1:0] err_cnt_o;

    wb_dma_slv_rsp_if bus ();

    wb_dma_slv_rsp #(
        .MEM_AW   (MEM_AW),
        .BASE_ADR (BASE),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wb           (bus),
        .ws_i         (ws_i),
        .rty_inject_i (rty_inject_i),
        .ack_cnt_o    (ack_cnt_o),
        .err_cnt_o    (err_cnt_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int checks = 0;
    int errors = 0;

    // Expected termination: 0 = ack, 1 = err, 2 = rty
    typedef struct {
        int unsigned      due;
        int               kind;
        logic [31:0]      dat;
        logic [CNT_W-1:0] ac;
        logic [CNT_W-1:0] ec;
    } exp_t;

    exp_t             exp_q[$];
    logic [31:0]      mem_m [int];
    logic [31:0]      dat_m = 32'd0;
    logic [CNT_W-1:0] ac_m  = '0;
    logic [CNT_W-1:0] ec_m  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Transaction-level reference: decide the outcome and update model state
    function automatic void model_issue(input bit we, input logic [31:0] adr,
                                        input logic [3:0] sel, input logic [31:0] d,
                                        input bit rty, input int unsigned due);
        exp_t        e;
        logic [31:0] b;
        logic [31:0] w;
        int          idx;
        bit          hit;
        b   = BASE;
        hit = ((adr >> (MEM_AW + 2)) == (b >> (MEM_AW + 2)));
        idx = int'((adr >> 2) % (2 ** MEM_AW));
        if (!hit) begin
            e.kind = 1;
            ec_m   = ec_m + 1'b1;
        end else if (rty) begin
            e.kind = 2;
        end else begin
            e.kind = 0;
            ac_m   = ac_m + 1'b1;
            if (we) begin
                w = mem_m.exists(idx) ? mem_m[idx] : 32'd0;
                for (int i = 0; i < 4; i++) begin
                    if (sel[i]) w[i*8 +: 8] = d[i*8 +: 8];
                end
                mem_m[idx] = w;
            end else begin
                dat_m = mem_m[idx];
            end
        end
        e.due = due;
        e.dat = dat_m;
        e.ac  = ac_m;
        e.ec  = ec_m;
        exp_q.push_back(e);
    endfunction

    // Monitor: every termination must match the head of the scoreboard
    exp_t mon_e;
    int   mon_kind;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (bus.wb_ack_o || bus.wb_err_o || bus.wb_rty_o) begin
                    mon_kind = bus.wb_ack_o ? 0 : (bus.wb_err_o ? 1 : 2);
                    chk("term_onehot", 32'($countones({bus.wb_ack_o, bus.wb_err_o, bus.wb_rty_o})), 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_term: got kind %0d at cycle %0d, expected none", mon_kind, cyc_n);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("term_cycle", cyc_n, mon_e.due);
                        chk("term_kind", mon_kind, mon_e.kind);
                        chk("rdata", bus.wb_data_o, mon_e.dat);
                        chk("ack_cnt", 32'(ack_cnt_o), 32'(mon_e.ac));
                        chk("err_cnt", 32'(err_cnt_o), 32'(mon_e.ec));
                    end
                end else if (exp_q.size() > 0 && cyc_n > exp_q[0].due) begin
                    mon_e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_term: got none by cycle %0d, expected kind %0d at cycle %0d",
                             cyc_n, mon_e.kind, mon_e.due);
                end
            end
        end
    end

    // One transfer; abort_at > 0 drops cyc before edge k+abort_at
    task automatic xfer(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] d, input int ws, input bit rty, input int abort_at);
        @(negedge clk);
        bus.wb_cyc_i  = 1'b1;
        bus.wb_stb_i  = 1'b1;
        bus.wb_we_i   = we;
        bus.wb_adr_i  = adr;
        bus.wb_sel_i  = sel;
        bus.wb_data_i = d;
        ws_i          = 4'(ws);
        rty_inject_i  = rty;
        if (abort_at == 0) model_issue(we, adr, sel, d, rty, cyc_n + 2 + ws);
        @(negedge clk);
        // Request is latched: scramble everything the responder must ignore
        ws_i          = 4'($urandom);
        rty_inject_i  = 1'($urandom);
        bus.wb_we_i   = 1'($urandom);
        bus.wb_adr_i  = $urandom;
        bus.wb_sel_i  = 4'($urandom);
        bus.wb_data_i = $urandom;
        if (ws > 0 && $urandom_range(0, 1) == 1) bus.wb_stb_i = 1'b0;
        if (abort_at > 0) begin
            repeat (abort_at - 1) @(negedge clk);
            bus.wb_cyc_i = 1'b0;
            bus.wb_stb_i = 1'b0;
            @(negedge clk);
        end else begin
            repeat (ws + 1) @(negedge clk);
            bus.wb_cyc_i = 1'b0;
            bus.wb_stb_i = 1'b0;
        end
    endtask

    // Read request held across n terminations: one transfer per ws+2 cycles
    task automatic held_read(input logic [31:0] adr, input int ws, input int n);
        int unsigned k;
        @(negedge clk);
        bus.wb_cyc_i  = 1'b1;
        bus.wb_stb_i  = 1'b1;
        bus.wb_we_i   = 1'b0;
        bus.wb_adr_i  = adr;
        bus.wb_sel_i  = 4'hF;
        bus.wb_data_i = 32'd0;
        ws_i          = 4'(ws);
        rty_inject_i  = 1'b0;
        k = cyc_n + 1;
        for (int i = 0; i < n; i++) model_issue(1'b0, adr, 4'hF, 32'd0, 1'b0, k + i * (ws + 2) + ws + 1);
        repeat (n * (ws + 2)) @(negedge clk);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish before %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int          p;
        int          ws;
        int          ab;
        logic [31:0] adr;

        bus.wb_cyc_i  = 1'b0;
        bus.wb_stb_i  = 1'b0;
        bus.wb_we_i   = 1'b0;
        bus.wb_adr_i  = 32'd0;
        bus.wb_sel_i  = 4'd0;
        bus.wb_data_i = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(bus.wb_ack_o), 32'd0);
        chk("rst_err", 32'(bus.wb_err_o), 32'd0);
        chk("rst_rty", 32'(bus.wb_rty_o), 32'd0);
        chk("rst_data", bus.wb_data_o, 32'd0);
        chk("rst_ack_cnt", 32'(ack_cnt_o), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait write then read
        xfer(1'b1, BASE + 32'h10, 4'hF, 32'hDEADBEEF, 0, 1'b0, 0);
        xfer(1'b0, BASE + 32'h10, 4'hF, 32'd0, 0, 1'b0, 0);
        chk("t1_rdata", bus.wb_data_o, 32'hDEADBEEF);
        chk("t1_ack_cnt", 32'(ack_cnt_o), 32'd2);

        // Wait states and held strobe
        xfer(1'b0, BASE + 32'h10, 4'hF, 32'd0, 3, 1'b0, 0);
        held_read(BASE + 32'h10, 3, 2);

        // Single-lane write merge
        xfer(1'b1, BASE + 32'h10, 4'b0010, 32'h0000AB00, 1, 1'b0, 0);
        xfer(1'b0, BASE + 32'h10, 4'hF, 32'd0, 0, 1'b0, 0);
        chk("t3_rdata", bus.wb_data_o, 32'hDEADABEF);

        // Out-of-window write aliases onto word 4 but must not touch it
        xfer(1'b1, BASE + 32'h1000 + 32'h10, 4'hF, 32'h12345678, 2, 1'b0, 0);
        chk("t4_err_cnt", 32'(err_cnt_o), 32'd1);
        chk("t4_ack_cnt", 32'(ack_cnt_o), 32'd7);
        xfer(1'b0, BASE + 32'h10, 4'hF, 32'd0, 0, 1'b0, 0);
        chk("t4_rdata", bus.wb_data_o, 32'hDEADABEF);

        // Aborted write during wait states, then a zero-wait read
        xfer(1'b1, BASE + 32'h10, 4'hF, 32'hCAFE0000, 5, 1'b0, 3);
        xfer(1'b0, BASE + 32'h10, 4'hF, 32'd0, 0, 1'b0, 0);
        chk("t5_rdata", bus.wb_data_o, 32'hDEADABEF);

        // Retry-injected write leaves RAM and counters alone
        xfer(1'b1, BASE + 32'h10, 4'hF, 32'h11111111, 0, 1'b1, 0);
        xfer(1'b0, BASE + 32'h10, 4'hF, 32'd0, 0, 1'b0, 0);
        chk("t6_rdata", bus.wb_data_o, 32'hDEADABEF);
        chk("t6_ack_cnt", 32'(ack_cnt_o), 32'd10);

        // Seed a pool of words so random reads have known contents
        for (int i = 0; i < 16; i++) xfer(1'b1, BASE + 32'(i * 17 * 4), 4'hF, $urandom, 0, 1'b0, 0);

        for (int n = 0; n < 150; n++) begin
            p   = $urandom_range(0, 15);
            adr = BASE + 32'(p * 17 * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) adr = adr + 32'h1000 * 32'($urandom_range(1, 8));
            ws  = $urandom_range(0, 4);
            ab  = (ws > 0 && $urandom_range(0, 7) == 0) ? $urandom_range(1, ws) : 0;
            xfer(1'($urandom), adr, 4'($urandom), $urandom, ws, $urandom_range(0, 5) == 0, ab);
        end

        // Reset in the middle of a wait-stated transfer
        @(negedge clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b1;
        bus.wb_adr_i = BASE;
        bus.wb_sel_i = 4'hF;
        ws_i         = 4'd5;
        rty_inject_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst2_ack", 32'(bus.wb_ack_o), 32'd0);
        chk("rst2_err", 32'(bus.wb_err_o), 32'd0);
        chk("rst2_rty", 32'(bus.wb_rty_o), 32'd0);
        chk("rst2_data", bus.wb_data_o, 32'd0);
        chk("rst2_ack_cnt", 32'(ack_cnt_o), 32'd0);
        chk("rst2_err_cnt", 32'(err_cnt_o), 32'd0);
        @(negedge clk);
        rst          = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        ac_m         = '0;
        ec_m         = '0;
        dat_m        = 32'd0;

        xfer(1'b0, BASE + 32'h10, 4'hF, 32'd0, 0, 1'b0, 0);
        chk("post_rst_rdata", bus.wb_data_o, 32'hDEADABEF);
        xfer(1'b0, BASE + 32'h1000, 4'hF, 32'd0, 2, 1'b0, 0);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
